// File: rtl/airi5c_float_packer_pkg.sv
// Shared FPU definitions: rounding modes, fflags layout, exponent limits and
// the packer state encoding.
package airi5c_float_packer_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Bit positions inside fflags = {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] CANONICAL_NAN_DEFAULT = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } packer_state_t;

endpackage

// File: rtl/airi5c_round_decide.sv
// Round-up / inexact decision from the LSB, guard, round and sticky bits.
// Purely combinational so every FPU rounding path can share it.
module airi5c_round_decide
  import airi5c_float_packer_pkg::*;
(
  input  logic       lsb,
  input  logic       guard,
  input  logic       round_bit,
  input  logic       sticky,
  input  logic       sgn,
  input  logic [2:0] rm,
  output logic       round_up,
  output logic       inexact
);

  assign inexact = guard | round_bit | sticky;

  // Unknown encodings fall through to round-to-nearest-even
  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sgn & inexact;
      RM_RUP:  round_up = ~sgn & inexact;
      RM_RMM:  round_up = guard;
      default: round_up = guard & (round_bit | sticky | lsb);
    endcase
  end

endmodule

// File: rtl/airi5c_float_packer.sv
// Normalises, rounds and packs an unrounded sign/exponent/mantissa result into
// an IEEE-754 binary32 word with fflags, behind valid/ready handshakes.
module airi5c_float_packer
  import airi5c_float_packer_pkg::*;
#(
  parameter int          EXP_W         = 10,
  parameter logic [31:0] CANONICAL_NAN = CANONICAL_NAN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    sgn,
  input  logic signed [EXP_W-1:0] Exp,
  input  logic [27:0]             man,
  input  logic                    zero,
  input  logic                    inf,
  input  logic                    sNaN,
  input  logic                    qNaN,
  input  logic [2:0]              rm,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [31:0]             float_out,
  output logic [4:0]              fflags
);

  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_LIMIT = EXP_W'(EXP_MAX);

  packer_state_t state, state_next;

  logic                    sgn_q;
  logic signed [EXP_W-1:0] exp_q;
  logic [27:0]             man_q;
  logic [2:0]              rm_q;

  logic        accept;
  logic        is_special;
  logic [31:0] special_word;
  logic [4:0]  special_flags;

  logic man_is_zero;
  logic shift_right;
  logic shift_left;
  logic norm_done;

  logic                    round_up;
  logic                    inexact;
  logic [24:0]             sum;
  logic [23:0]             mant_r;
  logic signed [EXP_W-1:0] exp_r;
  logic                    tiny;
  logic                    overflow;
  logic                    sat_inf;
  logic [31:0]             round_word;
  logic [4:0]              round_flags;

  assign ready_out  = (state == ST_IDLE);
  assign valid_out  = (state == ST_DONE);
  assign accept     = valid_in && ready_out;
  assign is_special = sNaN | qNaN | inf | zero;

  // NaN outranks infinity, which outranks zero
  always_comb begin
    special_word  = {sgn, 31'h0};
    special_flags = '0;
    if (sNaN || qNaN) begin
      special_word           = CANONICAL_NAN;
      special_flags[FLAG_NV] = sNaN;
    end else if (inf) begin
      special_word = {sgn, 8'hFF, 23'h0};
    end
  end

  // One normalisation step per cycle; right shifts (carry or denormalise) win
  assign man_is_zero = (man_q == 28'd0);
  assign shift_right = !man_is_zero && (man_q[27] || (exp_q < EXP_ONE));
  assign shift_left  = !man_is_zero && !man_q[26] && (exp_q > EXP_ONE);
  assign norm_done   = !shift_right && !shift_left;

  airi5c_round_decide u_round_decide (
    .lsb      (man_q[3]),
    .guard    (man_q[2]),
    .round_bit(man_q[1]),
    .sticky   (man_q[0]),
    .sgn      (sgn_q),
    .rm       (rm_q),
    .round_up (round_up),
    .inexact  (inexact)
  );

  // A denormal that rounds into the hidden bit picks up exponent field 1 for free
  always_comb begin
    sum      = {1'b0, man_q[26:3]} + {24'd0, round_up};
    mant_r   = sum[24] ? sum[24:1] : sum[23:0];
    exp_r    = sum[24] ? exp_q + EXP_ONE : exp_q;
    tiny     = (exp_q == EXP_ONE) && !man_q[26];
    overflow = mant_r[23] && (exp_r >= EXP_LIMIT);

    sat_inf = 1'b1;
    case (rm_q)
      RM_RTZ:  sat_inf = 1'b0;
      RM_RDN:  sat_inf = sgn_q;
      RM_RUP:  sat_inf = ~sgn_q;
      default: sat_inf = 1'b1;
    endcase

    round_flags          = '0;
    round_flags[FLAG_DZ] = 1'b0;
    round_flags[FLAG_OF] = overflow;
    round_flags[FLAG_UF] = tiny && inexact;
    round_flags[FLAG_NX] = inexact || overflow;

    if (overflow) begin
      round_word = sat_inf ? {sgn_q, 8'hFF, 23'h0} : {sgn_q, 31'h7F7FFFFF};
    end else begin
      round_word = {sgn_q, (mant_r[23] ? exp_r[7:0] : 8'h00), mant_r[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_special ? ST_DONE : ST_NORM;
        end
      end
      ST_NORM: begin
        if (norm_done) begin
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: state_next = ST_DONE;
      ST_DONE: begin
        if (ready_in) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, shifter and result registers; rm is frozen at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_q     <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      rm_q      <= RM_RNE;
      float_out <= '0;
      fflags    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sgn_q <= sgn;
            exp_q <= Exp;
            man_q <= man;
            rm_q  <= rm;
            if (is_special) begin
              float_out <= special_word;
              fflags    <= special_flags;
            end
          end
        end
        ST_NORM: begin
          if (shift_right) begin
            man_q <= {1'b0, man_q[27:2], man_q[1] | man_q[0]};
            exp_q <= exp_q + EXP_ONE;
          end else if (shift_left) begin
            man_q <= {man_q[26:0], 1'b0};
            exp_q <= exp_q - EXP_ONE;
          end
        end
        ST_ROUND: begin
          float_out <= round_word;
          fflags    <= round_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_airi5c_float_packer.sv
// Randomised and directed bench for the binary32 packer, checked against an
// exact-arithmetic rounding model.
module tb_airi5c_float_packer;

  logic              clk;
  logic              reset;
  logic              valid_in;
  logic              ready_out;
  logic              sgn;
  logic signed [9:0] Exp;
  logic [27:0]       man;
  logic              zero;
  logic              inf;
  logic              sNaN;
  logic              qNaN;
  logic [2:0]        rm;
  logic              valid_out;
  logic              ready_in;
  logic [31:0]       float_out;
  logic [4:0]        fflags;

  int total = 0;
  int bad   = 0;

  airi5c_float_packer dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .sgn      (sgn),
    .Exp      (Exp),
    .man      (man),
    .zero     (zero),
    .inf      (inf),
    .sNaN     (sNaN),
    .qNaN     (qNaN),
    .rm       (rm),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .float_out(float_out),
    .fflags   (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  // Exact model: value = man * 2^(Exp-153); round to the binary32 grid whose
  // step is 2^(e-23) for normals and never finer than 2^-149.
  // lat = clock edges after the accepting edge until valid_out shows.
  function automatic void refModel(input logic s, input int ex, input logic [27:0] mn,
                                   input logic [3:0] spec, input logic [2:0] mode,
                                   output logic [31:0] w, output logic [4:0] fl, output int lat);
    int p, e, q, sh, fieldE, expFinal;
    longint m, rem, half;
    bit inexact, aboveHalf, atHalf, up, tiny, toInf;
    w = {s, 31'h0};
    fl = 5'h00;
    lat = 0;
    if (spec[3] || spec[2]) begin
      w = 32'h7FC00000;
      fl = {spec[3], 4'h0};
      return;
    end
    if (spec[1]) begin
      w = {s, 8'hFF, 23'h0};
      return;
    end
    if (spec[0]) return;
    lat = 2;
    if (mn == 28'h0) return;
    p = 0;
    for (int b = 0; b < 28; b++) if (mn[b]) p = b;
    expFinal = (ex + p - 26 > 1) ? ex + p - 26 : 1;
    lat = 2 + ((expFinal > ex) ? expFinal - ex : ex - expFinal);
    e = ex + p - 153;
    q = (e - 23 > -149) ? e - 23 : -149;
    sh = q - (ex - 153);
    m = 0;
    rem = 0;
    half = 0;
    if (sh <= 0) begin
      m = longint'(mn) <<< (-sh);
    end else if (sh >= 30) begin
      rem = longint'(mn);
      half = longint'(1) <<< 40;
    end else begin
      m = longint'(mn) >>> sh;
      rem = longint'(mn) - (m <<< sh);
      half = longint'(1) <<< (sh - 1);
    end
    inexact = (rem != 0);
    aboveHalf = inexact && (rem > half);
    atHalf = inexact && (rem == half);
    case (mode)
      3'd1: up = 1'b0;
      3'd2: up = s && inexact;
      3'd3: up = !s && inexact;
      3'd4: up = aboveHalf || atHalf;
      default: up = aboveHalf || (atHalf && m[0]);
    endcase
    if (up) m = m + 1;
    if (m == (longint'(1) <<< 24)) begin
      m = longint'(1) <<< 23;
      q++;
    end
    fieldE = (m >= (longint'(1) <<< 23)) ? q + 150 : 0;
    tiny = (e < -126);
    if (fieldE >= 255) begin
      case (mode)
        3'd1: toInf = 1'b0;
        3'd2: toInf = s;
        3'd3: toInf = !s;
        default: toInf = 1'b1;
      endcase
      w = toInf ? {s, 8'hFF, 23'h0} : {s, 31'h7F7FFFFF};
      fl = 5'b00101;
    end else begin
      w = {s, 8'(fieldE), 23'(m)};
      fl = {3'b000, tiny && inexact, inexact};
    end
  endfunction

  // One full transaction: accept, wait for the result, hold it, then release
  task automatic applyStimulus(input logic s, input int ex, input logic [27:0] mn,
                               input logic [3:0] spec, input logic [2:0] mode,
                               input logic [31:0] wantWord, input logic [4:0] wantFlags,
                               input int wantLat, input int hold);
    int cyc;
    cyc = 0;
    while (!ready_out && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("ready_out_idle", 32'(ready_out), 32'd1);
    sgn = s;
    Exp = 10'(ex);
    man = mn;
    {sNaN, qNaN, inf, zero} = spec;
    rm = mode;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    sgn = ~s;
    Exp = 10'($urandom);
    man = 28'($urandom);
    {sNaN, qNaN, inf, zero} = 4'($urandom);
    rm = 3'($urandom);
    cyc = 0;
    while (!valid_out && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(wantLat));
    checkOutput("float_out", float_out, wantWord);
    checkOutput("fflags", 32'(fflags), 32'(wantFlags));
    checkOutput("ready_out_busy", 32'(ready_out), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      rm = 3'($urandom);
      checkOutput("hold_valid", 32'(valid_out), 32'd1);
      checkOutput("hold_float", float_out, wantWord);
      checkOutput("hold_fflags", 32'(fflags), 32'(wantFlags));
      checkOutput("hold_ready_out", 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    checkOutput("release_valid", 32'(valid_out), 32'd0);
    checkOutput("release_ready", 32'(ready_out), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [4:0]  fl;
    int          lat;
    logic        s;
    int          ex;
    logic [27:0] mn;
    logic [3:0]  spec;
    logic [2:0]  mode;
    int          p;
    logic [31:0] mask;

    reset = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    sgn = 1'b0;
    Exp = '0;
    man = '0;
    {sNaN, qNaN, inf, zero} = 4'h0;
    rm = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready_out", 32'(ready_out), 32'd1);
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_float_out", float_out, 32'h0);
    checkOutput("reset_fflags", 32'(fflags), 32'h0);
    reset = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 127, 28'h4000000, 4'b0000, 3'd0, 32'h3F800000, 5'h00, 2, 0);
    applyStimulus(1'b0, 127, 28'h400000C, 4'b0000, 3'd0, 32'h3F800002, 5'h01, 2, 1);
    applyStimulus(1'b0, 127, 28'h400000C, 4'b0000, 3'd1, 32'h3F800001, 5'h01, 2, 0);
    applyStimulus(1'b0, 255, 28'h4000000, 4'b0000, 3'd0, 32'h7F800000, 5'h05, 2, 0);
    applyStimulus(1'b0, 255, 28'h4000000, 4'b0000, 3'd1, 32'h7F7FFFFF, 5'h05, 2, 0);
    applyStimulus(1'b1, 255, 28'h4000000, 4'b0000, 3'd3, 32'hFF7FFFFF, 5'h05, 2, 0);
    applyStimulus(1'b0, 127, 28'h0000008, 4'b0000, 3'd0, 32'h34000000, 5'h00, 25, 0);
    applyStimulus(1'b0, -22, 28'h4000000, 4'b0000, 3'd0, 32'h00000001, 5'h00, 25, 0);
    // Sticky survives the denormalising shifts and RUP bumps the LSB
    applyStimulus(1'b0, -22, 28'h4000001, 4'b0000, 3'd3, 32'h00000002, 5'h03, 25, 0);
    applyStimulus(1'b0, 127, 28'h8000000, 4'b0000, 3'd0, 32'h40000000, 5'h00, 3, 0);
    applyStimulus(1'b0, 127, 28'h4000000, 4'b1000, 3'd0, 32'h7FC00000, 5'h10, 0, 0);
    applyStimulus(1'b1, 127, 28'h4000000, 4'b0010, 3'd0, 32'hFF800000, 5'h00, 0, 0);
    applyStimulus(1'b1, 127, 28'h4000000, 4'b0001, 3'd0, 32'h80000000, 5'h00, 0, 0);
    applyStimulus(1'b1, 127, 28'h4000000, 4'b0111, 3'd0, 32'h7FC00000, 5'h00, 0, 0);
    applyStimulus(1'b1, 127, 28'h4000000, 4'b0000, 3'd0, 32'hBF800000, 5'h00, 2, 3);

    $display("[TB] reset during normalisation");
    sgn = 1'b0;
    Exp = 10'sd127;
    man = 28'h0000008;
    {sNaN, qNaN, inf, zero} = 4'h0;
    rm = 3'd0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_ready_out", 32'(ready_out), 32'd1);
    checkOutput("midreset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("midreset_float_out", float_out, 32'h0);
    checkOutput("midreset_fflags", 32'(fflags), 32'h0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midreset_no_stale", 32'(valid_out), 32'd0);

    $display("[TB] random cases");
    for (int n = 0; n < 250; n++) begin
      s = 1'($urandom);
      spec = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      case ($urandom_range(0, 3))
        0: ex = int'($urandom_range(100, 160));
        1: ex = int'($urandom_range(240, 300));
        2: ex = int'($urandom_range(0, 40)) - 30;
        default: ex = int'($urandom_range(0, 446)) - 63;
      endcase
      p = int'($urandom_range(0, 27));
      mask = (32'd1 << p) - 32'd1;
      mn = 28'(($urandom & mask) | (32'd1 << p));
      if ($urandom_range(0, 39) == 0) mn = 28'h0;
      mode = 3'($urandom_range(0, 7));
      refModel(s, ex, mn, spec, mode, w, fl, lat);
      applyStimulus(s, ex, mn, spec, mode, w, fl, lat, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
